// File: rtl/maxpool_pkg.sv
// Shared definitions for the max-pooling stage: datapath width, pooled-size
// helper and a signed maximum used by both compare levels.
package maxpool_pkg;

  // Sample width shared with the PE and relu accumulators.
  localparam int unsigned DATA_WIDTH = 48;

  // Widest sample the max helper supports; callers sign-extend into it.
  localparam int unsigned MAX_DW = 64;

  // Pooled map size for an incoming map of size fm (floor division).
  function automatic int unsigned out_size(input int unsigned fm);
    return fm / 2;
  endfunction

  // Signed maximum; ties return either operand, which carry the same value.
  function automatic logic signed [MAX_DW-1:0] smax(input logic signed [MAX_DW-1:0] a,
                                                    input logic signed [MAX_DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Half-width line buffer holding one horizontal max per output column.
// Ports:
//   i_clk          clock
//   i_we           write enable
//   i_waddr/i_wdata write port
//   i_raddr        asynchronous read address
//   o_rdata        read data (combinational)
// Contents are not reset: every entry is written on an even row before the
// following odd row reads it.
module pool_linebuf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 48,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic signed [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]           i_raddr,
  output logic signed [WIDTH-1:0] o_rdata
);

  generate
    if (DEPTH == 1) begin : g_single
      // Single entry: addresses carry no information.
      logic signed [WIDTH-1:0] r_mem;
      logic                    w_unused_addr;

      assign w_unused_addr = ^{i_waddr, i_raddr};

      always_ff @(posedge i_clk) begin
        if (i_we) r_mem <= i_wdata;
      end

      assign o_rdata = r_mem;
    end else begin : g_array
      logic signed [WIDTH-1:0] r_mem [DEPTH];

      always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
      end

      assign o_rdata = r_mem[i_raddr];
    end
  endgenerate

endmodule

// File: rtl/maxpool.sv
// Streaming 2x2 stride-2 max pooling on a raster-ordered feature map.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_en, i_data    input sample valid / signed sample (row-major)
//   o_en            one-cycle pulse per pooled result
//   o_data          pooled result, held between pulses
//   o_last          marks the final result of a frame (with o_en)
module maxpool #(
  parameter int unsigned FM_SIZE    = 4,
  parameter int unsigned DATA_WIDTH = maxpool_pkg::DATA_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_en,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_last
);

  import maxpool_pkg::*;

  localparam int unsigned OUT_SIZE = out_size(FM_SIZE);
  localparam int unsigned CW       = $clog2(FM_SIZE);
  localparam int unsigned LB_AW    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(FM_SIZE - 1);
  localparam logic [CW-1:0] POOL_END = CW'(2 * OUT_SIZE - 1);

  logic [CW-1:0]               r_col;
  logic [CW-1:0]               r_row;
  logic signed [DATA_WIDTH-1:0] r_pair;

  logic                         w_col_wrap;
  logic                         w_lb_we;
  logic [LB_AW-1:0]             w_lb_addr;
  logic signed [DATA_WIDTH-1:0] w_hmax;
  logic signed [DATA_WIDTH-1:0] w_lb_rdata;
  logic signed [DATA_WIDTH-1:0] w_pmax;
  logic                         w_emit;

  // Odd FM_SIZE leaves an even trailing row/column, so the odd-index tests
  // alone already exclude it from pooling.
  assign w_col_wrap = (r_col == LAST_IDX);
  assign w_lb_addr  = LB_AW'(r_col >> 1);
  assign w_lb_we    = i_en && r_col[0] && !r_row[0];
  assign w_emit     = i_en && r_col[0] && r_row[0];

  // Horizontal then vertical max.
  assign w_hmax = DATA_WIDTH'(smax(MAX_DW'(r_pair), MAX_DW'(i_data)));
  assign w_pmax = DATA_WIDTH'(smax(MAX_DW'(w_hmax), MAX_DW'(w_lb_rdata)));

  pool_linebuf #(
    .DEPTH (OUT_SIZE),
    .WIDTH (DATA_WIDTH),
    .AW    (LB_AW)
  ) u_linebuf (
    .i_clk   (i_clk),
    .i_we    (w_lb_we),
    .i_waddr (w_lb_addr),
    .i_wdata (w_hmax),
    .i_raddr (w_lb_addr),
    .o_rdata (w_lb_rdata)
  );

  // Raster position counters and horizontal pair capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_pair <= '0;
    end else if (i_en) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= (r_row == LAST_IDX) ? '0 : r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
      if (!r_col[0]) r_pair <= i_data;
    end
  end

  // Output registers; o_data holds between pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_en   <= 1'b0;
      o_last <= 1'b0;
      o_data <= '0;
    end else begin
      o_en   <= w_emit;
      o_last <= w_emit && (r_row == POOL_END) && (r_col == POOL_END);
      if (w_emit) o_data <= w_pmax;
    end
  end

endmodule

// File: doc/maxpool.md
# maxpool

Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of `relu` in the convolution datapath. It consumes the rectified convolution results (`o_en`/`o_data` of `relu`) in raster order and emits one pooled value per 2x2 window. It uses a half-width line buffer, so the whole output feature map never has to be stored.

## Interface
- `FM_SIZE`, default 4: width and height of the incoming map, i.e. `(FM - KERNEL + 2*PADDING)/STRIDE + 1` of the PE. Must be ≥ 2.
- `DATA_WIDTH`, default 48: sample width, signed. Matches the PE/`relu` accumulator width.
- Derived constant `OUT_SIZE` = `FM_SIZE/2`, using floor division.
- `i_clk`, in, 1: clock. All state updates on the rising edge.
- `i_rst_n`, in, 1: reset, asynchronous and active-low.
- `i_en`, in, 1: input sample valid. One sample is accepted per cycle in which it is high.
- `i_data`, in, `DATA_WIDTH`, signed: input sample, raster order (row-major, top-left first).
- `o_en`, out, 1: pooled result valid. Single-cycle pulse per result.
- `o_data`, out, `DATA_WIDTH`, signed: pooled result.
- `o_last`, out, 1: high together with `o_en` on the final result of a frame.

## Operation
- Counters `col` and `row` each run from 0 to `FM_SIZE-1`.
  - `col` advances on every accepted sample.
  - `col` wraps at `FM_SIZE-1` and increments `row`.
  - `row` wraps at `FM_SIZE-1` back to frame start. There is no gap needed between frames.
- Horizontal pair handling:
  - Even `col`: the sample is captured in `pair_reg`.
  - Odd `col`: `hmax = max(pair_reg, i_data)` is formed, signed compare.
- Even `row`, odd `col`: `hmax` is written to line buffer entry `col/2`.
- Odd `row`, odd `col`: the result `max(hmax, linebuf[col/2])` is registered into `o_data` and `o_en` pulses.
- `o_last` is set when `row == 2*OUT_SIZE-1` and `col == 2*OUT_SIZE-1`.
- Odd `FM_SIZE`: the last column (`col == FM_SIZE-1`) and the last row (`row == FM_SIZE-1`) are consumed and discarded. Counters still advance through them.
- `FM_SIZE == 2`: a single result per frame, with `o_last` set on it.
- Ties resolve to either operand; the value is identical.
- No saturation and no width change. `o_data` is exactly `DATA_WIDTH` bits.
- `i_en` low: counters, `pair_reg` and the line buffer hold their state. There is no timeout, so idle gaps of any length are legal.
- No back-pressure. The block accepts every `i_en` cycle.

## Timing
- Latency: `o_en` rises exactly 1 cycle after the rising edge that accepts the bottom-right sample of a window.
- `o_en` and `o_last` are high for exactly 1 cycle per result. `o_data` holds its last value while `o_en` is low.
- Maximum output rate: 1 result every 2 accepted samples, on odd rows only.
- Reset values: `o_en = 0`, `o_last = 0`, `o_data = 0`, `col = row = 0`, `pair_reg = 0`.
  - Line buffer contents are not cleared. Every entry is always written on an even row before it is read.
- Reset mid-frame: the partial frame is discarded. The first sample accepted after `i_rst_n` deasserts is treated as `(0,0)`. No `o_en` may be produced from pre-reset data.
- `i_en` during reset is ignored.

## Structure
- Shared package holds:
  - the `DATA_WIDTH` constant (48, shared with PE/`relu`);
  - an `out_size(fm)` function;
  - the signed max helper.
- One sub-module, `pool_linebuf`:
  - depth `OUT_SIZE`, width `DATA_WIDTH`;
  - 1 write port and 1 asynchronous read port, register array, no reset.
- The top level holds the counters, `pair_reg`, the compare logic and the output registers.

## Test plan
- **Basic frame:** `FM_SIZE=4`, inputs 1..16 back-to-back → `o_data` 6, 8, 14, 16. Each `o_en` is 1 cycle after samples 6, 8, 14, 16 are accepted. `o_last` is set only with 16.
- **Odd size:** `FM_SIZE=5`, inputs 1..25 → 7, 9, 17, 19, with `o_last` on 19. Row 4 and column 4 are dropped. No `o_en` occurs during samples 21..25.
- **Gapped input and signed compare:** `FM_SIZE=4`, inputs −16..−1 with `i_en` low on every other cycle → results −11, −9, −3, −1. Outputs are the same as with contiguous input apart from timing. `o_data` holds between pulses.
- **Back-to-back frames:** `FM_SIZE=4`, inputs 1..32 contiguous → 6, 8, 14, 16, 22, 24, 30, 32. `o_last` is set on 16 and 32.
- **Reset mid-frame:** `FM_SIZE=4`, send 1..10, then pulse `i_rst_n` low asynchronously between clock edges.
  - While reset is low, `o_en`, `o_last` and `o_data` are 0.
  - Then send 1..16 → only 6, 8, 14, 16 appear.
- **Minimal map:** `FM_SIZE=2`, inputs 3, 9, 4, 1 → a single output of 9 with `o_en` and `o_last` both set.
